// File: rtl/rsb_ctrl_if.sv
// rsb_ctrl_if -- bundle of every rsb_ctrl signal except clk/rst.
//
// Signal groups:
//   fetch lanes  : ln0/ln1 valid, is_call, is_ret, ret_addr (64b) -> controller
//   handshake    : ev_ready_o (controller -> fetch), flush_i (-> controller)
//   RSB drive    : rsb_push_o, rsb_pop_o, rsb_push_addr_o (controller -> RSB)
//   RSB status   : rsb_top_i, rsb_overflow_i, rsb_underflow_i (RSB -> controller)
//   prediction   : pred_valid_o, pred_target_o
//   counters     : ovf_cnt_o, unf_cnt_o
//
// Modports:
//   slave  -- the controller (rsb_ctrl) side
//   master -- the environment side (fetch unit + return stack buffer)
interface rsb_ctrl_if;
    logic        ln0_valid_i;
    logic        ln1_valid_i;
    logic        ln0_is_call_i;
    logic        ln1_is_call_i;
    logic        ln0_is_ret_i;
    logic        ln1_is_ret_i;
    logic [63:0] ln0_ret_addr_i;
    logic [63:0] ln1_ret_addr_i;
    logic        ev_ready_o;
    logic        flush_i;
    logic        rsb_push_o;
    logic        rsb_pop_o;
    logic [63:0] rsb_push_addr_o;
    logic [63:0] rsb_top_i;
    logic        rsb_overflow_i;
    logic        rsb_underflow_i;
    logic        pred_valid_o;
    logic [63:0] pred_target_o;
    logic [31:0] ovf_cnt_o;
    logic [31:0] unf_cnt_o;

    modport slave (
        input  ln0_valid_i, ln1_valid_i,
        input  ln0_is_call_i, ln1_is_call_i, ln0_is_ret_i, ln1_is_ret_i,
        input  ln0_ret_addr_i, ln1_ret_addr_i,
        input  flush_i, rsb_top_i, rsb_overflow_i, rsb_underflow_i,
        output ev_ready_o, rsb_push_o, rsb_pop_o, rsb_push_addr_o,
        output pred_valid_o, pred_target_o, ovf_cnt_o, unf_cnt_o
    );

    modport master (
        output ln0_valid_i, ln1_valid_i,
        output ln0_is_call_i, ln1_is_call_i, ln0_is_ret_i, ln1_is_ret_i,
        output ln0_ret_addr_i, ln1_ret_addr_i,
        output flush_i, rsb_top_i, rsb_overflow_i, rsb_underflow_i,
        input  ev_ready_o, rsb_push_o, rsb_pop_o, rsb_push_addr_o,
        input  pred_valid_o, pred_target_o, ovf_cnt_o, unf_cnt_o
    );
endinterface

// File: rtl/rsb_ctrl.sv
// rsb_ctrl -- return stack buffer controller.
//
// Buffers call/ret events from two fetch lanes in a small FIFO and replays
// them one per cycle onto the return stack buffer: a call head pushes its
// return address, a ret head pops and publishes rsb_top_i as the predicted
// return target. flush_i discards everything and holds the block idle for
// two cycles.
//
// Ports:
//   clk  -- sole clock, posedge
//   rst  -- asynchronous, active-high reset
//   bus  -- rsb_ctrl_if.slave (lanes, ev_ready, flush, RSB drive/status,
//           prediction, perf counters)
//
// Parameter:
//   FIFO_DEPTH -- buffered events, power of two, >= 2
//
// Build option:
//   RSB_CTRL_PERF_EN -- when defined, ovf_cnt_o/unf_cnt_o are saturating
//                       counts of overflowing pushes / underflowing pops;
//                       otherwise both are tied to zero.
module rsb_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    rsb_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t             state_reg;
    logic               flush_hold_reg;   // 1 = first FLUSH cycle, 0 = last
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;

    // Entry = {is_call, address}. The head is read asynchronously so an
    // event accepted at edge N can drive the RSB in cycle N+1.
    logic [64:0]        mem [FIFO_DEPTH];

    logic [1:0]         lane_valid;
    logic [1:0]         lane_call;
    logic [1:0]         lane_ret;
    logic [1:0]         lane_take;
    logic [63:0]        lane_addr  [2];
    logic [64:0]        lane_entry [2];

    logic               run_open;
    logic               ev_ready;
    logic               head_valid;
    logic [64:0]        head_entry;
    logic               push;
    logic               pop;
    logic               deq;
    logic [PTR_W-1:0]   wr_ptr_lane1;

    assign lane_valid   = {bus.ln1_valid_i,   bus.ln0_valid_i};
    assign lane_call    = {bus.ln1_is_call_i, bus.ln0_is_call_i};
    assign lane_ret     = {bus.ln1_is_ret_i,  bus.ln0_is_ret_i};
    assign lane_addr[0] = bus.ln0_ret_addr_i;
    assign lane_addr[1] = bus.ln1_ret_addr_i;

    // RUN and not being flushed this very cycle; rst gates everything so the
    // outputs fall the instant reset rises.
    assign run_open = !rst && (state_reg == ST_RUN) && !bus.flush_i;
    assign ev_ready = run_open && (count_reg <= DEPTH_C - CNT_W'(2));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_take[gi]  = lane_valid[gi] && ev_ready &&
                                    (lane_call[gi] || lane_ret[gi]);
            // A lane flagged both call and ret is stored as a call.
            assign lane_entry[gi] = {lane_call[gi], lane_addr[gi]};
        end
    endgenerate

    assign head_entry = mem[rd_ptr_reg];
    assign head_valid = run_open && (count_reg != '0);
    assign push       = head_valid && head_entry[64];
    assign pop        = head_valid && !head_entry[64];
    assign deq        = head_valid;

    // Lane 1 lands after lane 0 when both are taken.
    assign wr_ptr_lane1 = wr_ptr_reg + PTR_W'(lane_take[0]);
    assign count_next   = count_reg + CNT_W'(lane_take[0])
                        + CNT_W'(lane_take[1]) - CNT_W'(deq);

    assign bus.ev_ready_o      = ev_ready;
    assign bus.rsb_push_o      = push;
    assign bus.rsb_pop_o       = pop;
    assign bus.rsb_push_addr_o = push ? head_entry[63:0] : 64'h0;
    assign bus.pred_valid_o    = pop;
    assign bus.pred_target_o   = pop ? bus.rsb_top_i : 64'h0;

    // Storage carries no reset; validity is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (lane_take[0]) begin
            mem[wr_ptr_reg] <= lane_entry[0];
        end
        if (lane_take[1]) begin
            mem[wr_ptr_lane1] <= lane_entry[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            flush_hold_reg <= 1'b0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (bus.flush_i) begin
                        state_reg      <= ST_FLUSH;
                        flush_hold_reg <= 1'b1;
                        rd_ptr_reg     <= '0;
                        wr_ptr_reg     <= '0;
                        count_reg      <= '0;
                    end else begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(deq);
                        wr_ptr_reg <= wr_ptr_lane1 + PTR_W'(lane_take[1]);
                        count_reg  <= count_next;
                    end
                end
                ST_FLUSH: begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                    if (bus.flush_i) begin
                        // Re-flush restarts the full two-cycle hold.
                        flush_hold_reg <= 1'b1;
                    end else if (!flush_hold_reg) begin
                        state_reg <= ST_RUN;
                    end else begin
                        flush_hold_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

`ifdef RSB_CTRL_PERF_EN
    logic [31:0] ovf_cnt_reg;
    logic [31:0] unf_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_reg <= '0;
            unf_cnt_reg <= '0;
        end else begin
            if (push && bus.rsb_overflow_i && (ovf_cnt_reg != '1)) begin
                ovf_cnt_reg <= ovf_cnt_reg + 32'd1;
            end
            if (pop && bus.rsb_underflow_i && (unf_cnt_reg != '1)) begin
                unf_cnt_reg <= unf_cnt_reg + 32'd1;
            end
        end
    end

    assign bus.ovf_cnt_o = ovf_cnt_reg;
    assign bus.unf_cnt_o = unf_cnt_reg;
`else
    // Status inputs are intentionally unused when counting is compiled out.
    logic unused_perf;
    assign unused_perf   = &{1'b0, bus.rsb_overflow_i, bus.rsb_underflow_i};
    assign bus.ovf_cnt_o = 32'h0;
    assign bus.unf_cnt_o = 32'h0;
`endif
endmodule

// File: doc/rsb_ctrl.md
RSB_CTRL -- requirements
Module: rsb_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered call/ret events (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports ln0_valid_i, ln1_valid_i  input  1 each  fetch lane event valid.
REQ-005 SHALL have ports ln0_is_call_i, ln1_is_call_i, ln0_is_ret_i, ln1_is_ret_i  input  1 each  event type.
REQ-006 SHALL have ports ln0_ret_addr_i, ln1_ret_addr_i  input  64 each  return address for a call.
REQ-007 SHALL have port ev_ready_o  output  1  both lanes may be accepted this cycle.
REQ-008 SHALL have port flush_i  input  1  discard all buffered and incoming events.
REQ-009 SHALL have ports rsb_push_o, rsb_pop_o  output  1 each, and rsb_push_addr_o  output  64  drive the return stack buffer.
REQ-010 SHALL have ports rsb_top_i  input  64, rsb_overflow_i and rsb_underflow_i  input  1 each  status from the return stack buffer.
REQ-011 SHALL have ports pred_valid_o  output  1 and pred_target_o  output  64  return-target prediction.
REQ-012 SHALL have ports ovf_cnt_o, unf_cnt_o  output  32 each  event counters.

Function
REQ-013 SHALL accept an event when lnX_valid_i && ev_ready_o && (is_call || is_ret); a lane with neither type set is ignored.
REQ-014 SHALL treat a lane with both is_call and is_ret set as a call.
REQ-015 SHALL assert ev_ready_o only in state RUN, and only when free FIFO entries >= 2.
REQ-016 SHALL enqueue lane 0 before lane 1 when both are accepted in the same cycle; occupancy increases by 0, 1 or 2.
REQ-017 SHALL dequeue at most one FIFO head per cycle in RUN; a dequeue and up to two enqueues in the same cycle are legal.
REQ-018 SHALL, for a call head, assert rsb_push_o with rsb_push_addr_o = the stored address; rsb_pop_o = 0.
REQ-019 SHALL, for a ret head, assert rsb_pop_o and pred_valid_o, with pred_target_o = rsb_top_i in that same cycle.
REQ-020 SHALL never assert rsb_push_o and rsb_pop_o together; with the FIFO empty, all three outputs are 0 and pred_target_o = 0.
REQ-021 SHALL have minimum latency of 1 cycle: an event accepted at edge N drives the RSB ports in cycle N+1. There is no bypass.
REQ-022 SHALL implement FSM RUN -> FLUSH on flush_i. In FLUSH: FIFO cleared at the entry edge, rsb_push_o/rsb_pop_o/pred_valid_o forced 0, ev_ready_o = 0, events presented are discarded.
REQ-023 SHALL stay in FLUSH for exactly 2 cycles, then return to RUN. flush_i asserted during FLUSH restarts the 2-cycle hold.
REQ-024 SHALL, when flush_i is high in RUN, gate RSB outputs to 0 and ignore lane events combinationally in that same cycle.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, using an occupancy count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-026 SHALL, while rst is high, hold: FSM = RUN, FIFO empty, pointers 0, counters 0.
REQ-027 SHALL, while rst is high, hold outputs: rsb_push_o = 0, rsb_pop_o = 0, pred_valid_o = 0, pred_target_o = 0, rsb_push_addr_o = 0, and ev_ready_o = 0.
REQ-028 SHALL, on reset asserted mid-operation, discard all buffered events immediately; no push or pop is issued after rst rises.

Configuration
REQ-029 SHALL, with RSB_CTRL_PERF_EN defined, make ovf_cnt_o/unf_cnt_o saturating 32-bit counts of cycles where rsb_push_o && rsb_overflow_i, and rsb_pop_o && rsb_underflow_i, respectively.
REQ-030 SHALL, without RSB_CTRL_PERF_EN, keep the ports present but tie them to 32'h0, with no counter flops.

Verification
REQ-031 SHALL cover: ln0 call addr 0x1000 accepted at cycle 0 -> cycle 1: rsb_push_o = 1, rsb_push_addr_o = 0x1000.
REQ-032 SHALL cover: same cycle, ln0 call 0x2000 and ln1 ret; rsb_top_i = 0x2000 in cycle 2 -> push 0x2000 in cycle 1; pop, pred_valid_o = 1, pred_target_o = 0x2000 in cycle 2.
REQ-033 SHALL cover: continuous dual calls with FIFO_DEPTH = 4 -> ev_ready_o drops when occupancy reaches 3; no event lost; pushes stay in order.
REQ-034 SHALL cover: 3 buffered events then flush_i for 1 cycle -> no push/pop that cycle or the following 2; ev_ready_o low 3 cycles; FIFO empty afterwards.
REQ-035 SHALL cover: pop with rsb_underflow_i = 1 for 5 cycles under RSB_CTRL_PERF_EN -> unf_cnt_o = 5; without the macro -> 0.
REQ-036 SHALL cover: rst pulse while 2 events are buffered -> all outputs 0 asynchronously; no RSB operation after release until a new event is accepted.
